// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Mode/Adv button controller for a 1 Hz alarm clock. Mode steps through
//   the time, date and alarm set states and back to RUN. Adv issues one-cycle
//   advance pulses for the field being set, and auto-repeats while held.
//   In RUN, Adv toggles the alarm enable instead.
//   An idle set state falls back to RUN after TIMEOUT quiet cycles.
//
// Parameters
//   HOLD_DLY : cycles Adv must be held before auto-repeat starts
//   RPT      : cycles between auto-repeat pulses (1 <= RPT <= HOLD_DLY)
//   TIMEOUT  : idle cycles in a set state before returning to RUN
//
// Ports
//   clk      : clock, 1 cycle per second, rising-edge active
//   rst      : asynchronous active-low reset
//   Mode     : mode button, level-high when pressed
//   Adv      : advance button, level-high when pressed
//   Timeset  : high in T_MIN..T_MON
//   Alarmset : high in A_MIN..A_DAY
//   Minadv, Hrsadv, Dayadv, Datadv, Monadv : one-cycle advance pulses
//   Alarmon  : alarm enable
//   Field    : current state code (RUN=0 .. A_DAY=8)
module clock_set_ctrl #(
  parameter int HOLD_DLY = 3,
  parameter int RPT      = 1,
  parameter int TIMEOUT  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Mode,
  input  logic       Adv,
  output logic       Timeset,
  output logic       Alarmset,
  output logic       Minadv,
  output logic       Hrsadv,
  output logic       Dayadv,
  output logic       Datadv,
  output logic       Monadv,
  output logic       Alarmon,
  output logic [3:0] Field
);

  localparam int HW = $clog2(HOLD_DLY) + 1;
  localparam int IW = $clog2(TIMEOUT) + 1;

  // Last count value before a repeat pulse fires, and the reload value that
  // spaces subsequent pulses RPT cycles apart.
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_DLY - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_DLY - RPT);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    RUN    = 4'd0,
    T_MIN  = 4'd1,
    T_HRS  = 4'd2,
    T_DAY  = 4'd3,
    T_DATE = 4'd4,
    T_MON  = 4'd5,
    A_MIN  = 4'd6,
    A_HRS  = 4'd7,
    A_DAY  = 4'd8
  } state_t;

  state_t          state_reg, state_next;
  logic            mode_hist_reg;
  logic            adv_hist_reg;
  logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
  logic            armed_reg, armed_next;
  logic [IW-1:0]   idle_cnt_reg, idle_cnt_next;
  logic            alarmon_reg, alarmon_next;
  // One-hot advance pulse: bit0 Min, bit1 Hrs, bit2 Day, bit3 Date, bit4 Mon
  logic [4:0]      pulse_reg, pulse_next;

  logic            mode_press;
  logic            adv_press;
  logic            fire;
  logic [4:0]      pulse_sel;

  assign mode_press = Mode & ~mode_hist_reg;
  assign adv_press  = Adv & ~adv_hist_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= RUN;
      // History bits start high so a button held through reset is no press.
      mode_hist_reg <= 1'b1;
      adv_hist_reg  <= 1'b1;
      hold_cnt_reg  <= '0;
      armed_reg     <= 1'b0;
      idle_cnt_reg  <= '0;
      alarmon_reg   <= 1'b0;
      pulse_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      mode_hist_reg <= Mode;
      adv_hist_reg  <= Adv;
      hold_cnt_reg  <= hold_cnt_next;
      armed_reg     <= armed_next;
      idle_cnt_reg  <= idle_cnt_next;
      alarmon_reg   <= alarmon_next;
      pulse_reg     <= pulse_next;
    end
  end

  // Field being set in the current state, as a one-hot pulse selector.
  always_comb begin
    pulse_sel = 5'b00000;
    case (state_reg)
      T_MIN, A_MIN: pulse_sel = 5'b00001;
      T_HRS, A_HRS: pulse_sel = 5'b00010;
      T_DAY, A_DAY: pulse_sel = 5'b00100;
      T_DATE:       pulse_sel = 5'b01000;
      T_MON:        pulse_sel = 5'b10000;
      default:      pulse_sel = 5'b00000;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = '0;
    armed_next    = 1'b0;
    idle_cnt_next = '0;
    alarmon_next  = alarmon_reg;
    fire          = 1'b0;

    if (mode_press) begin
      // Mode wins over a coincident Adv press; clearing armed means a held
      // Adv stays silent until it is released and pressed again.
      case (state_reg)
        RUN:     state_next = T_MIN;
        T_MIN:   state_next = T_HRS;
        T_HRS:   state_next = T_DAY;
        T_DAY:   state_next = T_DATE;
        T_DATE:  state_next = T_MON;
        T_MON:   state_next = A_MIN;
        A_MIN:   state_next = A_HRS;
        A_HRS:   state_next = A_DAY;
        A_DAY:   state_next = RUN;
        default: state_next = RUN;
      endcase
    end else if (state_reg == RUN) begin
      if (adv_press) begin
        alarmon_next = ~alarmon_reg;
      end
    end else begin
      if (adv_press) begin
        fire       = 1'b1;
        armed_next = 1'b1;
      end else if (Adv && armed_reg) begin
        armed_next = 1'b1;
        if (hold_cnt_reg >= HOLD_LAST) begin
          fire          = 1'b1;
          hold_cnt_next = HOLD_RELOAD;
        end else begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
        end
      end

      // Any button activity keeps the idle counter at zero.
      if (!Mode && !Adv) begin
        if (idle_cnt_reg >= IDLE_LAST) begin
          state_next = RUN;
        end else begin
          idle_cnt_next = idle_cnt_reg + IW'(1);
        end
      end
    end

    pulse_next = fire ? pulse_sel : 5'b00000;
  end

  assign Field    = state_reg;
  assign Timeset  = (state_reg >= T_MIN) && (state_reg <= T_MON);
  assign Alarmset = (state_reg >= A_MIN) && (state_reg <= A_DAY);
  assign Minadv   = pulse_reg[0];
  assign Hrsadv   = pulse_reg[1];
  assign Dayadv   = pulse_reg[2];
  assign Datadv   = pulse_reg[3];
  assign Monadv   = pulse_reg[4];
  assign Alarmon  = alarmon_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
//   Directed self-checking bench for clock_set_ctrl with default parameters
//   (HOLD_DLY=3, RPT=1, TIMEOUT=30). Inputs change 1 time unit after a
//   rising edge and outputs are sampled at that same point.
module tb_clock_set_ctrl;

  logic       clk;
  logic       rst;
  logic       Mode;
  logic       Adv;
  logic       Timeset;
  logic       Alarmset;
  logic       Minadv;
  logic       Hrsadv;
  logic       Dayadv;
  logic       Datadv;
  logic       Monadv;
  logic       Alarmon;
  logic [3:0] Field;
  logic [4:0] pulses;

  int n_cmp = 0;
  int n_bad = 0;

  clock_set_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .Mode     (Mode),
    .Adv      (Adv),
    .Timeset  (Timeset),
    .Alarmset (Alarmset),
    .Minadv   (Minadv),
    .Hrsadv   (Hrsadv),
    .Dayadv   (Dayadv),
    .Datadv   (Datadv),
    .Monadv   (Monadv),
    .Alarmon  (Alarmon),
    .Field    (Field)
  );

  // Pulse vector order: {Minadv, Hrsadv, Dayadv, Datadv, Monadv}
  assign pulses = {Minadv, Hrsadv, Dayadv, Datadv, Monadv};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) begin
      $display("check %-14s observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] seen;
    logic [3:0] exp_field;

    rst  = 1'b0;
    Mode = 1'b0;
    Adv  = 1'b1;   // held through reset: must not count as a press
    #2;
    check("rst_field", 32'(Field), 32'd0);
    check("rst_flags", 32'({Timeset, Alarmset, Alarmon}), 32'd0);
    check("rst_pulses", 32'(pulses), 32'd0);
    #10 rst = 1'b1;

    tick();
    check("held_at_rst", 32'(Alarmon), 32'd0);
    Adv = 1'b0;
    tick();

    // Enter T_MIN, single Adv press gives one Minadv pulse.
    Mode = 1'b1; tick();
    check("tmin_field", 32'(Field), 32'd1);
    check("tmin_sets", 32'({Timeset, Alarmset}), 32'b10);
    Mode = 1'b0; tick();
    Adv = 1'b1; tick();
    check("min_pulse", 32'(pulses), 32'b10000);
    Adv = 1'b0; tick();
    check("min_pulse_end", 32'(pulses), 32'd0);

    // T_HRS auto-repeat: pulses at hold counts 0,3,4,5,6,7.
    Mode = 1'b1; tick();
    check("thrs_field", 32'(Field), 32'd2);
    Mode = 1'b0; tick();
    Adv = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("hrs_rpt%0d", k), 32'(pulses),
            (k == 0 || k >= 3) ? 32'b01000 : 32'd0);
    end
    Adv = 1'b0; tick();
    check("hrs_release", 32'(pulses), 32'd0);
    tick();
    check("hrs_quiet", 32'(pulses), 32'd0);

    // T_DAY: Mode and Adv together -> Mode wins, Adv locked until released.
    Mode = 1'b1; tick();
    check("tday_field", 32'(Field), 32'd3);
    Mode = 1'b0; tick();
    Mode = 1'b1; Adv = 1'b1; tick();
    check("both_field", 32'(Field), 32'd4);
    check("both_pulse", 32'(pulses), 32'd0);
    Mode = 1'b0; tick();
    check("held_adv", 32'(pulses), 32'd0);
    tick();
    check("held_adv2", 32'(pulses), 32'd0);
    Adv = 1'b0; tick();
    Adv = 1'b1; tick();
    check("date_pulse", 32'(pulses), 32'b00010);
    Adv = 1'b0; tick();
    check("date_end", 32'(pulses), 32'd0);

    // T_MON advance pulse.
    Mode = 1'b1; tick();
    check("tmon_field", 32'(Field), 32'd5);
    Mode = 1'b0; tick();
    Adv = 1'b1; tick();
    check("mon_pulse", 32'(pulses), 32'b00001);
    Adv = 1'b0; tick();

    // A_MIN then 30 idle cycles -> RUN on the 30th idle edge.
    Mode = 1'b1; tick();
    check("amin_field", 32'(Field), 32'd6);
    check("amin_sets", 32'({Timeset, Alarmset}), 32'b01);
    Mode = 1'b0;
    seen = '0;
    for (int i = 1; i <= 29; i++) begin
      tick();
      seen = seen | pulses;
    end
    check("idle29_field", 32'(Field), 32'd6);
    tick();
    seen = seen | pulses;
    check("timeout_field", 32'(Field), 32'd0);
    check("timeout_pulse", 32'(seen), 32'd0);

    // Mode cycle from RUN: 1..8 then 0.
    for (int i = 1; i <= 9; i++) begin
      exp_field = 4'(i % 9);
      Mode = 1'b1; tick();
      check($sformatf("cyc%0d_field", i), 32'(Field), 32'(exp_field));
      check($sformatf("cyc%0d_sets", i), 32'({Timeset, Alarmset}),
            {30'd0, (exp_field >= 4'd1 && exp_field <= 4'd5),
                    (exp_field >= 4'd6 && exp_field <= 4'd8)});
      Mode = 1'b0; tick();
    end

    // RUN: Adv toggles Alarmon once, hold does not repeat, async reset.
    Adv = 1'b1; tick();
    check("alarm_on", 32'(Alarmon), 32'd1);
    check("run_nopulse", 32'(pulses), 32'd0);
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | pulses;
    end
    check("alarm_hold", 32'(Alarmon), 32'd1);
    check("run_hold_pulse", 32'(seen), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("async_alarm", 32'(Alarmon), 32'd0);
    check("async_field", 32'(Field), 32'd0);
    check("async_flags", 32'({Timeset, Alarmset, pulses}), 32'd0);
    #1 rst = 1'b1;
    tick();
    check("post_rst_hold", 32'(Alarmon), 32'd0);

    // Reset during an active advance pulse.
    Adv = 1'b0;
    Mode = 1'b1; tick();
    Mode = 1'b0; tick();
    Adv = 1'b1; tick();
    check("pre_rst_pulse", 32'(pulses), 32'b10000);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_pulse", 32'({Field, pulses}), 32'd0);
    #1 rst = 1'b1;
    Adv = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
